fractal_sync_port_arbiter: RTL



---
 rtl/fractal_sync_pkg.sv | 39 +++
 rtl/fractal_sync_rr_arb.sv | 34 +++
 rtl/fractal_sync_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal-sync port arbiter.
package fractal_sync_pkg;

    localparam int unsigned FSYNC_ID_W   = 4;
    localparam int unsigned FSYNC_AGGR_W = 1;

    typedef struct packed {
        logic [FSYNC_ID_W-1:0] id;
    } fsync_req_sig_t;

    typedef struct packed {
        logic           sync;
        logic           lock;
        logic           free;
        fsync_req_sig_t sig;
    } fsync_req_t;

    typedef struct packed {
        logic [FSYNC_AGGR_W-1:0] aggr;
        logic [FSYNC_ID_W-1:0]   id;
    } fsync_rsp_sig_t;

    typedef struct packed {
        logic           wake;
        logic           grant;
        fsync_rsp_sig_t sig;
        logic           error;
    } fsync_rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam fsync_rsp_t FSYNC_RSP_ERROR = '{wake: 1'b0, grant: 1'b0, sig: '0, error: 1'b1};

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module fractal_sync_rr_arb #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // upper segment [ptr, N_REQ) first, then wrap to [0, ptr)
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fractal_sync_port_arbiter.sv
// Shares one fractal-sync node port among N_REQ requesters, one outstanding request at a time.
module fractal_sync_port_arbiter #(
    parameter type         fsync_req_t    = fractal_sync_pkg::fsync_req_t,
    parameter type         fsync_rsp_t    = fractal_sync_pkg::fsync_rsp_t,
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  fsync_req_t       req_i [N_REQ],
    input  logic [N_REQ-1:0] req_valid_i,
    output logic [N_REQ-1:0] req_ready_o,
    output fsync_rsp_t       rsp_o [N_REQ],
    output logic [N_REQ-1:0] rsp_valid_o,
    output fsync_req_t       up_req_o,
    input  fsync_rsp_t       up_rsp_i,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             spurious_o
);

    import fractal_sync_pkg::*;

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic well_formed(input fsync_req_t r);
        return (2'(r.sync) + 2'(r.lock) + 2'(r.free)) == 2'd1;
    endfunction

    function automatic fsync_rsp_t error_rsp();
        fsync_rsp_t r;
        r       = '0;
        r.error = 1'b1;
        return r;
    endfunction

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fsync_req_t       slot_q [N_REQ];
    fsync_req_t       slot_d [N_REQ];
    fsync_rsp_t       cap_q, cap_d;
    fsync_req_t       up_req_q, up_req_d;
    fsync_rsp_t       rsp_q [N_REQ];
    fsync_rsp_t       rsp_d [N_REQ];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    fsync_req_t       pick_req;
    logic             ev;

    fractal_sync_rr_arb #(
        .N_REQ (N_REQ)
    ) i_rr_arb (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign ev = up_rsp_i.wake | up_rsp_i.grant | up_rsp_i.error;

    always_comb begin
        pick_req = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                pick_req = slot_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        cap_d       = cap_q;
        up_req_d    = '0;
        rsp_d       = rsp_q;
        rsp_valid_d = '0;
        timeout_o   = 1'b0;
        spurious_o  = 1'b0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid_i[i] && !pending_q[i]) begin
                slot_d[i]    = req_i[i];
                pending_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                spurious_o = ev;
                if (arb_valid) begin
                    sel_d = arb_idx;
                    if (well_formed(pick_req)) begin
                        up_req_d = pick_req;
                        state_d  = ISSUE;
                    end else begin
                        cap_d   = error_rsp();
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (ev) begin
                    cap_d   = up_rsp_i;
                    state_d = DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ev) begin
                    cap_d   = up_rsp_i;
                    state_d = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    timeout_o = 1'b1;
                    cap_d     = error_rsp();
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                spurious_o         = ev;
                rsp_d[sel_q]       = cap_q;
                rsp_valid_d[sel_q] = 1'b1;
                pending_d[sel_q]   = 1'b0;
                ptr_d              = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            slot_q      <= '{default: '0};
            cap_q       <= '0;
            up_req_q    <= '0;
            rsp_q       <= '{default: '0};
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            cap_q       <= cap_d;
            up_req_q    <= up_req_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o = ~pending_q;
    assign rsp_o       = rsp_q;
    assign rsp_valid_o = rsp_valid_q;
    assign up_req_o    = up_req_q;
    assign busy_o      = (state_q != IDLE);

endmodule
